// File: rtl/multi_pulse_seq.sv
// multi_pulse_seq: NCH-channel pulse-train sequencer with a period counter,
// shadowed configuration committed atomically at period boundaries, and an inhibit gate.
module multi_pulse_seq #(
    parameter int NCH = 4,
    parameter int CW = 16,
    parameter int PW = 24,
    parameter int INHIB_HOLD = 8,
    localparam int AW = $clog2(NCH) + 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           enable,
    input  logic           cfg_we,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [CW-1:0]  cfg_wdata,
    input  logic [PW-1:0]  per_in,
    input  logic           cfg_commit,
    output logic           commit_pending,
    output logic           sync,
    output logic [NCH-1:0] pulse_out,
    output logic           inhib
);
    localparam int HW = INHIB_HOLD > 0 ? $clog2(INHIB_HOLD + 1) : 1;

    typedef enum logic [2:0] {IDLE, DELAY, HIGH, GAP, DONE} state_t;

    logic [PW-1:0] pc, sh_per, act_per, sh_per_n, per_eff;
    logic [HW-1:0] hcnt;
    logic [NCH-1:0] hi;
    logic start, ld;

    assign start = enable && pc == '0;
    assign sh_per_n = cfg_commit ? per_in : sh_per;
    // a commit landing on a period start applies to that same period
    assign ld = (start && (commit_pending || cfg_commit)) || (!enable && commit_pending);
    assign per_eff = act_per < PW'(2) ? PW'(2) : act_per;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc <= '0;
            sh_per <= '0;
            act_per <= '0;
            commit_pending <= 1'b0;
            sync <= 1'b0;
            pulse_out <= '0;
            inhib <= 1'b0;
            hcnt <= '0;
        end else begin
            pc <= !enable || pc == per_eff - PW'(1) ? '0 : pc + PW'(1);
            if (cfg_commit) sh_per <= per_in;
            if (ld) act_per <= sh_per_n;
            commit_pending <= !ld && (commit_pending || cfg_commit);
            sync <= start;
            pulse_out <= hi;
            inhib <= |hi || hcnt != '0;
            hcnt <= |hi ? HW'(INHIB_HOLD) : hcnt == '0 ? '0 : hcnt - HW'(1);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CW-1:0] sh_dly, sh_wid, sh_spc, sh_cnt;
        logic [CW-1:0] a_dly, a_wid, a_spc, a_cnt;
        logic [CW-1:0] dly, wid, spc, cnt;
        logic [CW-1:0] ph, ph_n, cp, rem, rem_n, cn;
        state_t st, st_n, cs;
        logic wr;

        assign wr = cfg_we && (cfg_addr >> 2) == AW'(c);
        assign dly = ld ? sh_dly : a_dly;
        assign wid = ld ? sh_wid : a_wid;
        assign spc = ld ? sh_spc : a_spc;
        assign cnt = ld ? sh_cnt : a_cnt;
        assign hi[c] = cs == HIGH;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                {sh_dly, sh_wid, sh_spc, sh_cnt} <= '0;
                {a_dly, a_wid, a_spc, a_cnt} <= '0;
                st <= IDLE;
                ph <= '0;
                rem <= '0;
            end else begin
                if (wr && cfg_addr[1:0] == 2'd0) sh_dly <= cfg_wdata;
                if (wr && cfg_addr[1:0] == 2'd1) sh_wid <= cfg_wdata;
                if (wr && cfg_addr[1:0] == 2'd2) sh_spc <= cfg_wdata;
                if (wr && cfg_addr[1:0] == 2'd3) sh_cnt <= cfg_wdata;
                if (ld) {a_dly, a_wid, a_spc, a_cnt} <= {sh_dly, sh_wid, sh_spc, sh_cnt};
                st <= st_n;
                ph <= ph_n;
                rem <= rem_n;
            end
        end

        // cs/cp/cn describe the phase of the current cycle; a period start overrides them
        always_comb begin
            cs = st;
            cp = ph;
            cn = rem;
            if (start) begin
                cs = cnt == '0 || wid == '0 ? DONE : dly == '0 ? HIGH : DELAY;
                cp = '0;
                cn = cnt;
            end
            if (!enable) cs = IDLE;
            st_n = cs;
            ph_n = cp + CW'(1);
            rem_n = cn;
            case (cs)
                DELAY: if (cp == dly - CW'(1)) begin
                    st_n = HIGH;
                    ph_n = '0;
                end
                HIGH: if (cp == wid - CW'(1)) begin
                    ph_n = '0;
                    rem_n = cn - CW'(1);
                    st_n = cn == CW'(1) ? DONE : spc == '0 ? HIGH : GAP;
                end
                GAP: if (cp == spc - CW'(1)) begin
                    st_n = HIGH;
                    ph_n = '0;
                end
                default: ph_n = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_pulse_seq.sv
// tb_multi_pulse_seq: scoreboard bench; a closed-form pc-based model predicts every output cycle.
module tb_multi_pulse_seq;
    localparam int NCH = 4;
    localparam int CW = 16;
    localparam int PW = 24;
    localparam int HOLD = 8;
    localparam int AW = $clog2(NCH) + 2;

    logic clk, resetn, enable, cfg_we, cfg_commit;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_wdata;
    logic [PW-1:0] per_in;
    logic commit_pending, sync, inhib;
    logic [NCH-1:0] pulse_out;

    multi_pulse_seq #(.NCH(NCH), .CW(CW), .PW(PW), .INHIB_HOLD(HOLD)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .per_in(per_in),
        .cfg_commit(cfg_commit), .commit_pending(commit_pending), .sync(sync),
        .pulse_out(pulse_out), .inhib(inhib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic s;
        logic [NCH-1:0] p;
        logic i;
        logic cp;
    } exp_t;
    exp_t sbq[$];

    int sh_d[NCH], sh_w[NCH], sh_s[NCH], sh_c[NCH];
    int ac_d[NCH], ac_w[NCH], ac_s[NCH], ac_c[NCH];
    int sh_per, ac_per, m_pc, m_hold;
    bit m_pend;
    exp_t e;
    bit m_st, m_ld;
    int shp, pe, d, w, s, n, ch;
    logic [NCH-1:0] pp;

    always @(posedge clk) begin
        if (!resetn) begin
            for (int c = 0; c < NCH; c++) begin
                sh_d[c] = 0; sh_w[c] = 0; sh_s[c] = 0; sh_c[c] = 0;
                ac_d[c] = 0; ac_w[c] = 0; ac_s[c] = 0; ac_c[c] = 0;
            end
            sh_per = 0; ac_per = 0; m_pc = 0; m_hold = 0; m_pend = 0;
            sbq.delete();
        end else begin
            m_st = enable && m_pc == 0;
            m_ld = (m_st && (m_pend || cfg_commit)) || (!enable && m_pend);
            shp = cfg_commit ? int'(per_in) : sh_per;
            pe = m_ld ? shp : ac_per;
            if (pe < 2) pe = 2;
            pp = '0;
            for (int c = 0; c < NCH; c++) begin
                d = m_ld ? sh_d[c] : ac_d[c];
                w = m_ld ? sh_w[c] : ac_w[c];
                s = m_ld ? sh_s[c] : ac_s[c];
                n = m_ld ? sh_c[c] : ac_c[c];
                if (enable && n != 0 && w != 0 && m_pc >= d)
                    pp[c] = (m_pc - d) / (w + s) < n && (m_pc - d) % (w + s) < w;
            end
            e.s = m_st;
            e.p = pp;
            e.cp = !m_ld && (m_pend || cfg_commit);
            e.i = |pp || m_hold > 0;
            m_hold = |pp ? HOLD : (m_hold > 0 ? m_hold - 1 : 0);
            if (m_ld) begin
                for (int c = 0; c < NCH; c++) begin
                    ac_d[c] = sh_d[c]; ac_w[c] = sh_w[c]; ac_s[c] = sh_s[c]; ac_c[c] = sh_c[c];
                end
                ac_per = shp;
            end
            if (cfg_we) begin
                ch = int'(cfg_addr >> 2);
                if (ch < NCH) begin
                    if (cfg_addr[1:0] == 2'd0) sh_d[ch] = int'(cfg_wdata);
                    if (cfg_addr[1:0] == 2'd1) sh_w[ch] = int'(cfg_wdata);
                    if (cfg_addr[1:0] == 2'd2) sh_s[ch] = int'(cfg_wdata);
                    if (cfg_addr[1:0] == 2'd3) sh_c[ch] = int'(cfg_wdata);
                end
            end
            sh_per = shp;
            m_pend = e.cp;
            m_pc = (!enable || m_pc == pe - 1) ? 0 : m_pc + 1;
            sbq.push_back(e);
        end
    end

    exp_t g;
    always @(negedge clk) begin
        if (resetn && sbq.size() > 0) begin
            g = sbq.pop_front();
            check("sync", sync, g.s);
            check("pulse_out", pulse_out, g.p);
            check("inhib", inhib, g.i);
            check("commit_pending", commit_pending, g.cp);
        end
    end

    task automatic tick(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wr(int c, int r, int v);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = AW'(c * 4 + r);
        cfg_wdata = CW'(v);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic cfg(int c, int dl, int wd, int sp, int ct);
        wr(c, 0, dl);
        wr(c, 1, wd);
        wr(c, 2, sp);
        wr(c, 3, ct);
    endtask

    task automatic commit(int p);
        @(negedge clk);
        cfg_commit = 1'b1;
        per_in = PW'(p);
        @(negedge clk);
        cfg_commit = 1'b0;
    endtask

    task automatic wait_pc(int v);
        for (int i = 0; i < 200 && m_pc != v; i++) @(negedge clk);
        check("wait_pc", 32'(m_pc), 32'(v));
    endtask

    task automatic check_zero(string tag);
        check({tag, "_sync"}, sync, 0);
        check({tag, "_pulse"}, pulse_out, 0);
        check({tag, "_inhib"}, inhib, 0);
        check({tag, "_pend"}, commit_pending, 0);
    endtask

    initial begin
        resetn = 1'b0;
        enable = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        per_in = '0;
        cfg_commit = 1'b0;
        tick(2);
        check_zero("reset");
        resetn = 1'b1;
        // single pulse, committed while disabled
        cfg(0, 5, 3, 0, 1);
        commit(20);
        tick(3);
        enable = 1'b1;
        tick(45);
        // pulse train on ch1
        cfg(1, 2, 2, 4, 3);
        commit(40);
        tick(90);
        // atomic width change mid-period
        wait_pc(10);
        wr(0, 1, 10);
        commit(40);
        tick(90);
        // truncation at the period end
        cfg(0, 15, 10, 0, 1);
        commit(20);
        tick(50);
        // abort during HIGH, then resume
        wait_pc(17);
        enable = 1'b0;
        tick(12);
        enable = 1'b1;
        tick(30);
        // commit coinciding with a period start
        wait_pc(0);
        cfg_commit = 1'b1;
        per_in = PW'(25);
        @(negedge clk);
        cfg_commit = 1'b0;
        tick(60);
        // degenerate configuration
        cfg(2, 0, 5, 0, 0);
        cfg(3, 1, 0, 1, 2);
        commit(1);
        tick(20);
        // randomised retuning
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: wr($urandom_range(0, NCH - 1), 0, $urandom_range(0, 7));
                1: wr($urandom_range(0, NCH - 1), 1, $urandom_range(0, 4));
                2: wr($urandom_range(0, NCH - 1), $urandom_range(2, 3), $urandom_range(0, 3));
                default: commit($urandom_range(0, 30));
            endcase
            if ($urandom_range(0, 9) == 0) enable = !enable;
            tick($urandom_range(1, 15));
        end
        enable = 1'b1;
        // asynchronous reset mid-train with a pending commit
        cfg(0, 1, 8, 2, 2);
        commit(30);
        tick(25);
        commit(30);
        tick(2);
        #2 resetn = 1'b0;
        #1 check_zero("async_rst");
        tick(2);
        resetn = 1'b1;
        tick(30);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
